// File: rtl/blink_rate_decoder_if.sv
// rtl/blink_rate_decoder_if.sv - blink input and decoded rate status bundle
interface blink_rate_decoder_if #(
  parameter int unsigned CNT_W = 25
);
  logic             iSIG;
  logic             oSK;
  logic             oVALID;
  logic             oERR;
  logic             oUPD;
  logic [CNT_W-1:0] oPERIOD;

  // Source side: drives the blink wave and observes the decode.
  modport master (
    output iSIG,
    input  oSK,
    input  oVALID,
    input  oERR,
    input  oUPD,
    input  oPERIOD
  );

  // Decoder side.
  modport slave (
    input  iSIG,
    output oSK,
    output oVALID,
    output oERR,
    output oUPD,
    output oPERIOD
  );
endinterface

// File: rtl/blink_rate_decoder.sv
// rtl/blink_rate_decoder.sv - measures blink period and decodes slow/fast rate
module blink_rate_decoder #(
  parameter int unsigned SLOW_PERIOD = 8388608,
  parameter int unsigned FAST_PERIOD = 2097152,
  parameter int unsigned TOL         = 1024,
  parameter int unsigned TIMEOUT     = 16777216,
  parameter int unsigned CNT_W       = 25
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  blink_rate_decoder_if.slave bus
);

  // Window bounds carry one spare bit so SLOW_PERIOD + TOL cannot overflow.
  localparam logic [CNT_W:0]   SLOW_LO = (CNT_W+1)'(SLOW_PERIOD - TOL);
  localparam logic [CNT_W:0]   SLOW_HI = (CNT_W+1)'(SLOW_PERIOD + TOL);
  localparam logic [CNT_W:0]   FAST_LO = (CNT_W+1)'(FAST_PERIOD - TOL);
  localparam logic [CNT_W:0]   FAST_HI = (CNT_W+1)'(FAST_PERIOD + TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sk_q, sk_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             upd_q, upd_d;
  logic [CNT_W-1:0] period_q, period_d;

  logic             rise;
  logic [CNT_W:0]   p_ext;
  logic             in_slow;
  logic             in_fast;

  // Bring the asynchronous blink wave into iCLK and keep one history stage.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.iSIG;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // The counter value at an edge is the period since the previous edge.
  assign p_ext   = {1'b0, cnt_q};
  assign in_slow = (p_ext >= SLOW_LO) && (p_ext <= SLOW_HI);
  assign in_fast = (p_ext >= FAST_LO) && (p_ext <= FAST_HI);

  // State, period counter and registered status outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sk_q     <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sk_q     <= sk_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      period_q <= period_d;
    end
  end

  // Next-state: start reference in IDLE, classify or time out in MEAS.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sk_d     = sk_q;
    valid_d  = valid_q;
    err_d    = err_q;
    upd_d    = 1'b0;
    period_d = period_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          // First edge only sets the reference point; nothing to classify yet.
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = ST_MEAS;
        end
      end

      ST_MEAS: begin
        if (rise) begin
          // An edge takes priority over a simultaneous timeout.
          period_d = cnt_q;
          upd_d    = 1'b1;
          cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
          if (in_slow) begin
            sk_d    = 1'b1;
            valid_d = 1'b1;
            err_d   = 1'b0;
          end else if (in_fast) begin
            sk_d    = 1'b0;
            valid_d = 1'b1;
            err_d   = 1'b0;
          end else begin
            valid_d = 1'b0;
            err_d   = 1'b1;
          end
        end else if (cnt_q == CNT_MAX) begin
          // Stuck input: report once and wait for a fresh reference edge.
          valid_d = 1'b0;
          err_d   = 1'b1;
          upd_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.oSK     = sk_q;
  assign bus.oVALID  = valid_q;
  assign bus.oERR    = err_q;
  assign bus.oUPD    = upd_q;
  assign bus.oPERIOD = period_q;

endmodule

// File: tb/tb_blink_rate_decoder.sv
// tb/tb_blink_rate_decoder.sv - randomized self-checking bench for blink_rate_decoder
module tb_blink_rate_decoder;

  localparam int SLOW = 32;
  localparam int FAST = 8;
  localparam int TOL  = 2;
  localparam int TMO  = 64;
  localparam int CW   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;

  typedef struct {
    bit upd;
    bit sk;
    bit valid;
    bit err;
    int period;
  } exp_t;

  exp_t pipe[$];
  bit   m_sk, m_valid, m_err;
  int   m_period;
  bit   have_ref;
  int   ref_idx;
  bit   prev_sig;

  blink_rate_decoder_if #(.CNT_W(CW)) bus ();

  blink_rate_decoder #(
    .SLOW_PERIOD(SLOW),
    .FAST_PERIOD(FAST),
    .TOL        (TOL),
    .TIMEOUT    (TMO),
    .CNT_W      (CW)
  ) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (sample %0d, t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  task automatic model_reset();
    exp_t z;
    z = '{upd: 1'b0, sk: 1'b0, valid: 1'b0, err: 1'b0, period: 0};
    pipe.delete();
    pipe.push_back(z);
    pipe.push_back(z);
    m_sk = 0; m_valid = 0; m_err = 0; m_period = 0;
    have_ref = 0; ref_idx = 0; prev_sig = 0; n = 0;
  endtask

  // Reference: a rise sampled at index n shows up in the outputs two clocks later.
  task automatic model_sample(input bit v, output exp_t e);
    bit rise;
    int p, ds, df;
    rise = v & ~prev_sig;
    prev_sig = v;
    e.upd = 1'b0;
    if (rise) begin
      if (have_ref) begin
        p  = n - ref_idx;
        ds = (p > SLOW) ? p - SLOW : SLOW - p;
        df = (p > FAST) ? p - FAST : FAST - p;
        e.upd = 1'b1;
        m_period = p;
        if (ds <= TOL) begin
          m_sk = 1; m_valid = 1; m_err = 0;
        end else if (df <= TOL) begin
          m_sk = 0; m_valid = 1; m_err = 0;
        end else begin
          m_valid = 0; m_err = 1;
        end
      end
      have_ref = 1;
      ref_idx  = n;
    end else if (have_ref && (n - ref_idx) == TMO) begin
      have_ref = 0;
      e.upd    = 1'b1;
      m_valid  = 0;
      m_err    = 1;
    end
    e.sk     = m_sk;
    e.valid  = m_valid;
    e.err    = m_err;
    e.period = m_period;
  endtask

  // Called at a falling edge: drive one sample, clock it, then compare.
  task automatic step(input bit v);
    exp_t e, cur;
    bus.iSIG = v;
    @(posedge clk);
    n++;
    model_sample(v, e);
    pipe.push_back(e);
    cur = pipe.pop_front();
    @(negedge clk);
    check_eq("upd",    bus.oUPD,    cur.upd);
    check_eq("sk",     bus.oSK,     cur.sk);
    check_eq("valid",  bus.oVALID,  cur.valid);
    check_eq("err",    bus.oERR,    cur.err);
    check_eq("period", bus.oPERIOD, cur.period);
  endtask

  task automatic wave(input int p, input int h, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < p; i++)
        step(i < h);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_sk"},     bus.oSK,     0);
    check_eq({tag, "_valid"},  bus.oVALID,  0);
    check_eq({tag, "_err"},    bus.oERR,    0);
    check_eq({tag, "_upd"},    bus.oUPD,    0);
    check_eq({tag, "_period"}, bus.oPERIOD, 0);
  endtask

  int bnd[15] = '{30, 34, 32, 35, 32, 11, 32, 29, 31, 33, 6, 10, 7, 9, 5};

  initial begin
    bit sw;
    int lb, p, h, mode, per;

    bus.iSIG = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Slow rate, then fast rate.
    wave(SLOW, SLOW / 2, 4);
    wave(FAST, FAST / 2, 6);

    // Window boundaries starting from a slow-valid decode.
    wave(SLOW, SLOW / 2, 2);
    foreach (bnd[i]) wave(bnd[i], bnd[i] / 2, 1);
    check_eq("bnd_sk_after_err", bus.oSK, m_sk);

    // Stuck low, then resume.
    wave(SLOW, SLOW / 2, 2);
    repeat (80) step(1'b0);
    check_eq("stuck_err", bus.oERR, 1);
    wave(SLOW, SLOW / 2, 3);
    check_eq("resume_valid", bus.oVALID, 1);

    // Asynchronous reset mid-period.
    wave(SLOW, SLOW / 2, 2);
    for (int i = 0; i < 20; i++) step(i < 16);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midrst");
    bus.iSIG = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wave(SLOW, SLOW / 2, 3);

    // Random periods, duties and repeat counts.
    for (int k = 0; k < 30; k++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       p = $urandom_range(SLOW - 4, SLOW + 4);
        1:       p = $urandom_range(FAST - 4, FAST + 4);
        2:       p = $urandom_range(3, 75);
        default: p = $urandom_range(60, 70);
      endcase
      h = $urandom_range(1, p - 1);
      wave(p, h, $urandom_range(1, 3));
    end

    // Loopback from a free-running counter with a rate switch.
    lb = $urandom_range(0, 255);
    sw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sw  = (k == 0) ? 1'b1 : ~sw;
      per = sw ? SLOW : FAST;
      for (int i = 0; i < 2 * per + 3; i++) begin
        step(sw ? lb[4] : lb[2]);
        lb++;
      end
      check_eq("track_sk", bus.oSK, sw);
      repeat ($urandom_range(0, 40)) begin
        step(sw ? lb[4] : lb[2]);
        lb++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
